// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package uart_pkg;

    // Transmit FSM states: one start bit, eight data bits, one stop bit
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Word offsets selected by addr[2]
    localparam logic UART_REG_TXDATA = 1'b0;
    localparam logic UART_REG_STATUS = 1'b1;

    // STATUS word layout
    localparam int ST_FULL      = 0;
    localparam int ST_IDLE      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; dout shows the head entry.
// Latency: a push is visible at dout/count after the next rising edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers, count and storage contents
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_mmap.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, FSM serialises them on tx.
// Latency: TXDATA write at edge E0 with the FSM idle drops tx after edge E1; frame = 10*CLK_DIV cycles.
// Backpressure: software polls STATUS.full; a write while full is dropped and sets sticky overflow.
module uart_tx_mmap
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] addr,
    input  logic        re,
    output logic [31:0] rd,
    input  logic        we,
    input  logic [31:0] wd,
    output logic        tx,
    output logic        tx_idle
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_mmap: CLK_DIV must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_mmap: FIFO_DEPTH must be a power of two, at least 2");
    end

    uart_state_t      state_q, state_d;
    logic             tx_q, tx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             ovf_q, ovf_d;

    logic             wr_txdata;
    logic             wr_status;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;
    logic             cnt_zero;
    logic [31:0]      status;

    // Upper address bits and upper data bits carry no meaning for this device
    logic unused_bits;
    assign unused_bits = ^{addr[31:3], wd[31:8]};

    assign wr_txdata = we && (addr[2] == UART_REG_TXDATA);
    assign wr_status = we && (addr[2] == UART_REG_STATUS);
    // Full is judged on the registered count, so a same-cycle pop never rescues a push
    assign fifo_push = wr_txdata && !fifo_full;
    assign cnt_zero  = (cnt_q == '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (wd[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow: set by a dropped push, cleared by writing STATUS bit 2
    always_comb begin
        ovf_d = ovf_q;
        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_status && wd[ST_OVF]) begin
            ovf_d = 1'b0;
        end
    end

    // STATUS word assembled from registered state only
    always_comb begin
        status                                = '0;
        status[ST_FULL]                       = fifo_full;
        status[ST_IDLE]                       = tx_idle;
        status[ST_OVF]                        = ovf_q;
        status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
    end

    // Read mux: TXDATA reads as zero, and nothing is driven without re
    always_comb begin
        rd = '0;
        if (re && (addr[2] == UART_REG_STATUS)) begin
            rd = status;
        end
    end

    // State register plus all datapath flops; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: each bit period ends when the baud counter hits zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = START;
            end
            START: begin
                if (cnt_zero) state_d = DATA;
            end
            DATA: begin
                if (cnt_zero && (idx_q == 3'd7)) state_d = STOP;
            end
            STOP: begin
                if (cnt_zero) state_d = fifo_empty ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: pop, shifter, bit index, baud counter and registered tx
    always_comb begin
        fifo_pop = 1'b0;
        tx_d     = tx_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    tx_d     = 1'b0;
                    cnt_d    = CNT_RELOAD;
                end
            end
            START: begin
                if (cnt_zero) begin
                    tx_d  = shift_q[0];
                    cnt_d = CNT_RELOAD;
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    cnt_d = CNT_RELOAD;
                    if (idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    // Chain straight into the next start bit when more data is queued
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        tx_d     = 1'b0;
                        cnt_d    = CNT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_idle = fifo_empty && (state_q == IDLE);

endmodule
